// File: rtl/common_pkg.sv
// Shared load/store encodings, data RAM geometry and LSU state type.
package common_pkg;

    localparam int unsigned DATA_RAM_DEPTH = 1024;

    // RV32I store funct3
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // RV32I load funct3
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } lsu_state_t;

    // True when funct3 names a real load or store for the given direction.
    function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
        if (is_store)
            return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
        return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
               (f3 == F3_LBU) || (f3 == F3_LHU);
    endfunction

endpackage

// File: rtl/load_extend.sv
// Selects the addressed byte/halfword of a memory word and sign- or zero-extends it.
import common_pkg::*;

module load_extend (
    input  logic [31:0] read_data,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  func3,
    output logic [31:0] ext_data_c
);

    logic [7:0]  byte_c;
    logic [15:0] half_c;

    // Lane select, then extension by load type.
    always_comb begin
        case (addr_lo)
            2'd0:    byte_c = read_data[7:0];
            2'd1:    byte_c = read_data[15:8];
            2'd2:    byte_c = read_data[23:16];
            default: byte_c = read_data[31:24];
        endcase
        half_c = addr_lo[1] ? read_data[31:16] : read_data[15:0];
        case (func3)
            F3_LB:   ext_data_c = {{24{byte_c[7]}}, byte_c};
            F3_LBU:  ext_data_c = {24'd0, byte_c};
            F3_LH:   ext_data_c = {{16{half_c[15]}}, half_c};
            F3_LHU:  ext_data_c = {16'd0, half_c};
            F3_LW:   ext_data_c = read_data;
            default: ext_data_c = 32'd0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: one load/store per handshake, registered memory
// outputs, extended load data returned over a valid/ready response.
// Optional macro LSU_MISALIGN_TRAP_EN: misaligned halfword/word accesses fault;
// otherwise the address is silently aligned.
import common_pkg::*;

module load_store_unit #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned MEM_ADDR_W = 10
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_is_store,
    input  logic [2:0]            req_func3,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [31:0]           resp_rdata,
    output logic                  resp_err,
    output logic [MEM_ADDR_W-1:0] byte_address,
    output logic [2:0]            store_func3,
    output logic                  write_enable,
    output logic [31:0]           write_data,
    input  logic [31:0]           read_data
);

    lsu_state_t            state, state_nxt;
    logic                  is_store_q, is_store_nxt;
    logic                  req_ready_nxt, resp_valid_nxt, resp_err_nxt, write_enable_nxt;
    logic [31:0]           resp_rdata_nxt, write_data_nxt;
    logic [MEM_ADDR_W-1:0] byte_address_nxt;
    logic [2:0]            store_func3_nxt;

    logic                  fault_c, is_half_c, is_word_c;
    logic [MEM_ADDR_W-1:0] mem_addr_c;
    logic [31:0]           lane_data_c, ext_data_c;

    // store_func3 also carries the load funct3; memory ignores it without write_enable.
    load_extend u_load_extend (
        .read_data  (read_data),
        .addr_lo    (byte_address[1:0]),
        .func3      (store_func3),
        .ext_data_c (ext_data_c)
    );

    // Request decode: fault detection, address alignment, store lane replication.
    always_comb begin
        is_half_c  = (req_func3[1:0] == 2'b01);
        is_word_c  = (req_func3[1:0] == 2'b10);
        mem_addr_c = req_addr[MEM_ADDR_W-1:0];
`ifdef LSU_MISALIGN_TRAP_EN
        fault_c = (|req_addr[ADDR_W-1:MEM_ADDR_W]) || !f3_legal(req_is_store, req_func3) ||
                  (is_half_c && req_addr[0]) || (is_word_c && (req_addr[1:0] != 2'b00));
`else
        fault_c = (|req_addr[ADDR_W-1:MEM_ADDR_W]) || !f3_legal(req_is_store, req_func3);
        if (is_half_c) mem_addr_c[0]   = 1'b0;
        if (is_word_c) mem_addr_c[1:0] = 2'b00;
`endif
        case (req_func3)
            F3_SB:   lane_data_c = {4{req_wdata[7:0]}};
            F3_SH:   lane_data_c = {2{req_wdata[15:0]}};
            default: lane_data_c = req_wdata;
        endcase
    end

    // Next state and next registered outputs; everything holds by default.
    always_comb begin
        state_nxt        = state;
        is_store_nxt     = is_store_q;
        req_ready_nxt    = req_ready;
        resp_valid_nxt   = resp_valid;
        resp_err_nxt     = resp_err;
        resp_rdata_nxt   = resp_rdata;
        byte_address_nxt = byte_address;
        store_func3_nxt  = store_func3;
        write_enable_nxt = 1'b0;
        write_data_nxt   = write_data;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    req_ready_nxt = 1'b0;
                    if (fault_c) begin
                        state_nxt      = RESP;
                        resp_valid_nxt = 1'b1;
                        resp_err_nxt   = 1'b1;
                        resp_rdata_nxt = 32'd0;
                    end else begin
                        state_nxt        = ACCESS;
                        is_store_nxt     = req_is_store;
                        byte_address_nxt = mem_addr_c;
                        store_func3_nxt  = req_func3;
                        write_data_nxt   = lane_data_c;
                        write_enable_nxt = req_is_store;
                    end
                end
            end
            ACCESS: begin
                state_nxt      = RESP;
                resp_valid_nxt = 1'b1;
                resp_err_nxt   = 1'b0;
                resp_rdata_nxt = is_store_q ? 32'd0 : ext_data_c;
            end
            RESP: begin
                if (resp_ready) begin
                    state_nxt      = IDLE;
                    req_ready_nxt  = 1'b1;
                    resp_valid_nxt = 1'b0;
                    resp_err_nxt   = 1'b0;
                    resp_rdata_nxt = 32'd0;
                end
            end
            default: begin
                state_nxt      = IDLE;
                req_ready_nxt  = 1'b1;
                resp_valid_nxt = 1'b0;
                resp_err_nxt   = 1'b0;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Output and request-context registers; reset drops any in-flight store.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            is_store_q   <= 1'b0;
            req_ready    <= 1'b1;
            resp_valid   <= 1'b0;
            resp_err     <= 1'b0;
            resp_rdata   <= 32'd0;
            byte_address <= '0;
            store_func3  <= F3_SW;
            write_enable <= 1'b0;
            write_data   <= 32'd0;
        end else begin
            is_store_q   <= is_store_nxt;
            req_ready    <= req_ready_nxt;
            resp_valid   <= resp_valid_nxt;
            resp_err     <= resp_err_nxt;
            resp_rdata   <= resp_rdata_nxt;
            byte_address <= byte_address_nxt;
            store_func3  <= store_func3_nxt;
            write_enable <= write_enable_nxt;
            write_data   <= write_data_nxt;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a byte-addressed data memory model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        req_valid = 1'b0, req_is_store = 1'b0, resp_ready = 1'b0;
    logic [2:0]  req_func3 = 3'b000;
    logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
    logic        req_ready, resp_valid, resp_err, write_enable;
    logic [31:0] resp_rdata, write_data, read_data;
    logic [9:0]  byte_address;
    logic [2:0]  store_func3;

    int vectors = 0;
    int miscompares = 0;
    int we_cnt = 0;
    logic [7:0] mem [0:1023];

    load_store_unit dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
        .req_func3(req_func3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .byte_address(byte_address), .store_func3(store_func3),
        .write_enable(write_enable), .write_data(write_data), .read_data(read_data)
    );

    always #5 clk = ~clk;

    assign read_data = {mem[{byte_address[9:2], 2'd3}], mem[{byte_address[9:2], 2'd2}],
                        mem[{byte_address[9:2], 2'd1}], mem[{byte_address[9:2], 2'd0}]};

    // Data memory model: writes the lane addressed by byte_address.
    always @(posedge clk) begin
        if (write_enable === 1'b1) begin
            we_cnt <= we_cnt + 1;
            case (store_func3)
                3'b000: mem[byte_address] <= write_data[{byte_address[1:0], 3'b000} +: 8];
                3'b001: begin
                    mem[{byte_address[9:1], 1'b0}] <= write_data[{byte_address[1], 4'b0000} +: 8];
                    mem[{byte_address[9:1], 1'b1}] <= write_data[{byte_address[1], 4'b1000} +: 8];
                end
                default: begin
                    mem[{byte_address[9:2], 2'd0}] <= write_data[7:0];
                    mem[{byte_address[9:2], 2'd1}] <= write_data[15:8];
                    mem[{byte_address[9:2], 2'd2}] <= write_data[23:16];
                    mem[{byte_address[9:2], 2'd3}] <= write_data[31:24];
                end
            endcase
        end
    end

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    // Present a request, wait for acceptance; returns #1 after the acceptance edge.
    task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd);
        req_valid = 1'b1; req_is_store = st; req_func3 = f3; req_addr = a; req_wdata = wd;
        for (int i = 0; i < 20 && req_ready !== 1'b1; i++) cyc();
        vectors++;
        if (req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL accept_timeout: req_ready got %b want 1", req_ready);
        end
        cyc();
        req_valid = 1'b0;
    endtask

    task automatic finish_resp();
        resp_ready = 1'b1; cyc(); resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        #2 reset_n = 1'b0;
        #1;
        vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL rst_req_ready: got %b want 1", req_ready); end
        vectors++; if (resp_valid !== 1'b0) begin miscompares++; $display("FAIL rst_resp_valid: got %b want 0", resp_valid); end
        vectors++; if (write_enable !== 1'b0) begin miscompares++; $display("FAIL rst_we: got %b want 0", write_enable); end
        vectors++; if (store_func3 !== 3'b010) begin miscompares++; $display("FAIL rst_store_func3: got %b want 010", store_func3); end
        vectors++; if ({resp_rdata, write_data, byte_address, resp_err} !== 75'd0) begin
            miscompares++; $display("FAIL rst_data: rdata %h wdata %h addr %h err %b want all 0", resp_rdata, write_data, byte_address, resp_err);
        end
        cyc(); cyc();
        reset_n = 1'b1;
        cyc();
    endtask

    task automatic test_word();
        int base;
        base = we_cnt;
        issue(1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
        vectors++; if (write_enable !== 1'b1) begin miscompares++; $display("FAIL sw_we: got %b want 1", write_enable); end
        vectors++; if (write_data !== 32'hDEADBEEF) begin miscompares++; $display("FAIL sw_wdata: got %h want deadbeef", write_data); end
        vectors++; if (byte_address !== 10'h010) begin miscompares++; $display("FAIL sw_addr: got %h want 010", byte_address); end
        vectors++; if (resp_valid !== 1'b0) begin miscompares++; $display("FAIL sw_early_valid: got %b want 0", resp_valid); end
        cyc();
        vectors++; if (resp_valid !== 1'b1 || resp_err !== 1'b0 || resp_rdata !== 32'd0) begin
            miscompares++; $display("FAIL sw_resp: valid %b err %b rdata %h want 1 0 0", resp_valid, resp_err, resp_rdata);
        end
        vectors++; if (write_enable !== 1'b0) begin miscompares++; $display("FAIL sw_we_drop: got %b want 0", write_enable); end
        finish_resp();
        vectors++; if (we_cnt - base !== 1) begin miscompares++; $display("FAIL sw_we_count: got %0d want 1", we_cnt - base); end
        vectors++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            miscompares++; $display("FAIL sw_idle: req_ready %b resp_valid %b want 1 0", req_ready, resp_valid);
        end
        issue(1'b0, 3'b010, 32'h10, 32'd0);
        cyc();
        vectors++; if (resp_valid !== 1'b1 || resp_rdata !== 32'hDEADBEEF || resp_err !== 1'b0) begin
            miscompares++; $display("FAIL lw_resp: valid %b rdata %h err %b want 1 deadbeef 0", resp_valid, resp_rdata, resp_err);
        end
        finish_resp();
    endtask

    task automatic test_byte();
        issue(1'b1, 3'b000, 32'h13, 32'h000000A5);
        vectors++; if (write_data !== 32'hA5A5A5A5) begin miscompares++; $display("FAIL sb_wdata: got %h want a5a5a5a5", write_data); end
        cyc(); finish_resp();
        issue(1'b0, 3'b000, 32'h13, 32'd0); cyc();
        vectors++; if (resp_rdata !== 32'hFFFFFFA5) begin miscompares++; $display("FAIL lb: got %h want ffffffa5", resp_rdata); end
        finish_resp();
        issue(1'b0, 3'b100, 32'h13, 32'd0); cyc();
        vectors++; if (resp_rdata !== 32'h000000A5) begin miscompares++; $display("FAIL lbu: got %h want 000000a5", resp_rdata); end
        finish_resp();
        issue(1'b0, 3'b010, 32'h10, 32'd0); cyc();
        vectors++; if (resp_rdata !== 32'hA5ADBEEF) begin miscompares++; $display("FAIL sb_lanes: got %h want a5adbeef", resp_rdata); end
        finish_resp();
    endtask

    task automatic test_half();
        issue(1'b1, 3'b001, 32'h22, 32'h00008001);
        vectors++; if (write_data !== 32'h80018001) begin miscompares++; $display("FAIL sh_wdata: got %h want 80018001", write_data); end
        cyc(); finish_resp();
        issue(1'b0, 3'b001, 32'h22, 32'd0); cyc();
        vectors++; if (resp_rdata !== 32'hFFFF8001) begin miscompares++; $display("FAIL lh: got %h want ffff8001", resp_rdata); end
        finish_resp();
        issue(1'b0, 3'b101, 32'h22, 32'd0); cyc();
        vectors++; if (resp_rdata !== 32'h00008001) begin miscompares++; $display("FAIL lhu: got %h want 00008001", resp_rdata); end
        finish_resp();
        issue(1'b0, 3'b010, 32'h20, 32'd0); cyc();
        vectors++; if (resp_rdata !== 32'h80012120) begin miscompares++; $display("FAIL sh_neighbours: got %h want 80012120", resp_rdata); end
        finish_resp();
    endtask

    task automatic test_fault();
        int base;
        base = we_cnt;
        issue(1'b0, 3'b010, 32'h402, 32'd0);
        vectors++; if (resp_valid !== 1'b1 || resp_err !== 1'b1 || resp_rdata !== 32'd0) begin
            miscompares++; $display("FAIL range_lw: valid %b err %b rdata %h want 1 1 0", resp_valid, resp_err, resp_rdata);
        end
        finish_resp();
        issue(1'b1, 3'b010, 32'h400, 32'h12345678);
        vectors++; if (resp_valid !== 1'b1 || resp_err !== 1'b1) begin
            miscompares++; $display("FAIL range_sw: valid %b err %b want 1 1", resp_valid, resp_err);
        end
        finish_resp();
        vectors++; if (we_cnt - base !== 0) begin miscompares++; $display("FAIL fault_we: got %0d writes want 0", we_cnt - base); end
        issue(1'b0, 3'b011, 32'h10, 32'd0);
        vectors++; if (resp_valid !== 1'b1 || resp_err !== 1'b1) begin
            miscompares++; $display("FAIL illegal_f3: valid %b err %b want 1 1", resp_valid, resp_err);
        end
        finish_resp();
`ifdef LSU_MISALIGN_TRAP_EN
        issue(1'b0, 3'b001, 32'h11, 32'd0);
        vectors++; if (resp_valid !== 1'b1 || resp_err !== 1'b1 || resp_rdata !== 32'd0) begin
            miscompares++; $display("FAIL misalign_lh: valid %b err %b rdata %h want 1 1 0", resp_valid, resp_err, resp_rdata);
        end
        finish_resp();
`else
        issue(1'b0, 3'b001, 32'h11, 32'd0);
        vectors++; if (byte_address !== 10'h010) begin miscompares++; $display("FAIL align_lh_addr: got %h want 010", byte_address); end
        cyc();
        vectors++; if (resp_rdata !== 32'hFFFFBEEF || resp_err !== 1'b0) begin
            miscompares++; $display("FAIL align_lh: rdata %h err %b want ffffbeef 0", resp_rdata, resp_err);
        end
        finish_resp();
        issue(1'b0, 3'b010, 32'h13, 32'd0); cyc();
        vectors++; if (resp_rdata !== 32'hA5ADBEEF || resp_err !== 1'b0) begin
            miscompares++; $display("FAIL align_lw: rdata %h err %b want a5adbeef 0", resp_rdata, resp_err);
        end
        finish_resp();
`endif
    endtask

    task automatic test_backpressure();
        issue(1'b0, 3'b010, 32'h10, 32'd0);
        cyc();
        req_valid = 1'b1; req_is_store = 1'b0; req_func3 = 3'b100; req_addr = 32'h13;
        for (int i = 0; i < 5; i++) begin
            vectors++; if (resp_valid !== 1'b1 || resp_rdata !== 32'hA5ADBEEF || req_ready !== 1'b0) begin
                miscompares++; $display("FAIL hold_%0d: valid %b rdata %h req_ready %b want 1 a5adbeef 0", i, resp_valid, resp_rdata, req_ready);
            end
            cyc();
        end
        resp_ready = 1'b1; cyc(); resp_ready = 1'b0;
        vectors++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            miscompares++; $display("FAIL bp_idle: req_ready %b valid %b want 1 0", req_ready, resp_valid);
        end
        cyc();
        req_valid = 1'b0;
        vectors++; if (req_ready !== 1'b0 || resp_valid !== 1'b0) begin
            miscompares++; $display("FAIL bp_accept: req_ready %b valid %b want 0 0", req_ready, resp_valid);
        end
        cyc();
        vectors++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h000000A5) begin
            miscompares++; $display("FAIL bp_pending: valid %b rdata %h want 1 000000a5", resp_valid, resp_rdata);
        end
        finish_resp();
    endtask

    task automatic test_reset_mid();
        issue(1'b1, 3'b010, 32'h40, 32'h12345678);
        vectors++; if (write_enable !== 1'b1) begin miscompares++; $display("FAIL mid_we_high: got %b want 1", write_enable); end
        reset_n = 1'b0;
        #1;
        vectors++; if (write_enable !== 1'b0 || req_ready !== 1'b1) begin
            miscompares++; $display("FAIL mid_async: we %b req_ready %b want 0 1", write_enable, req_ready);
        end
        cyc();
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            vectors++; if (resp_valid !== 1'b0) begin miscompares++; $display("FAIL mid_no_resp_%0d: got %b want 0", i, resp_valid); end
        end
        issue(1'b0, 3'b010, 32'h40, 32'd0); cyc();
        vectors++; if (resp_rdata !== 32'h43424140) begin miscompares++; $display("FAIL mid_mem: got %h want 43424140", resp_rdata); end
        finish_resp();
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 8'(i);
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_fault();
        test_backpressure();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
